dvp_pixel_pack: RTL and testbench

DVP_PIXEL_PACK -- requirements
Module: dvp_pixel_pack

---
 rtl/dvp_pixel_pack.sv | 152 +++++++++++++++
 tb/tb_dvp_pixel_pack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pixel_pack.sv
// DVP camera byte stream to 16-bit pixel packer with frame skip, line/frame size
// measurement and odd-byte detection. Single clock domain (camera pixel clock).
module dvp_pixel_pack #(
  parameter int unsigned BYTE_ORDER  = 1,
  parameter int unsigned VSYNC_POL   = 1,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  output logic        o_video_valid,
  output logic [15:0] o_video_data,
  output logic        o_video_field,
  output logic [15:0] o_video_width,
  output logic [15:0] o_video_high,
  output logic        o_capture_active,
  output logic        o_odd_byte_err
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, ACTIVE} state_t;

  localparam logic VS_ACT = (VSYNC_POL != 0);

  state_t      r_state, w_state_n;
  logic        r_s1_vs, r_s2_vs, r_s1_hr, r_s2_hr;
  logic [7:0]  r_s1_data, r_byte0;
  logic [1:0]  r_arm, r_vld_pipe;
  logic [15:0] r_skip_cnt, r_pix_cnt, r_line_cnt, r_pix;
  logic        r_phase;
  logic        w_vs_rise, w_hr_rise, w_hr_fall, w_act, w_byte_en, w_phase, w_pix_fire;
  logic        w_line_end, w_skip_done;
  logic [15:0] w_pix, w_lines_nx;

  // Input sync; edge detection stays off until s2 holds real samples so the
  // reset values never look like an edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_vs   <= ~VS_ACT;
      r_s2_vs   <= ~VS_ACT;
      r_s1_hr   <= 1'b0;
      r_s2_hr   <= 1'b0;
      r_s1_data <= '0;
      r_arm     <= '0;
    end else begin
      r_s1_vs   <= i_cam_vsync;
      r_s2_vs   <= r_s1_vs;
      r_s1_hr   <= i_cam_href;
      r_s2_hr   <= r_s1_hr;
      r_s1_data <= i_cam_data;
      r_arm     <= {r_arm[0], 1'b1};
    end
  end

  assign w_vs_rise = r_arm[1] && (r_s1_vs == VS_ACT) && (r_s2_vs != VS_ACT);
  assign w_hr_rise = r_arm[1] && r_s1_hr && !r_s2_hr;
  assign w_hr_fall = r_arm[1] && !r_s1_hr && r_s2_hr;

  assign w_act       = (r_state == ACTIVE) && i_enable;
  assign w_byte_en   = w_act && r_s1_hr && (r_s1_vs != VS_ACT);
  assign w_phase     = r_phase && !w_hr_rise;
  assign w_pix_fire  = w_byte_en && w_phase;
  assign w_pix       = (BYTE_ORDER != 0) ? {r_byte0, r_s1_data} : {r_s1_data, r_byte0};
  // s2 vsync gates line end so a line finishing on the vsync edge still counts
  assign w_line_end  = w_act && w_hr_fall && (r_s2_vs != VS_ACT);
  assign w_lines_nx  = !w_line_end ? r_line_cnt :
                       (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
  assign w_skip_done = (32'(r_skip_cnt) + 32'd1) >= SKIP_FRAMES;

  always_comb begin
    w_state_n = r_state;
    if (!i_enable) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_n = WAIT_VS;
        WAIT_VS: if (w_vs_rise) w_state_n = (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
        SKIP:    if (w_vs_rise && w_skip_done) w_state_n = ACTIVE;
        default: w_state_n = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= IDLE;
      r_skip_cnt       <= '0;
      o_video_field    <= 1'b0;
      o_capture_active <= 1'b0;
    end else begin
      r_state          <= w_state_n;
      o_video_field    <= w_vs_rise && (w_state_n == ACTIVE);
      o_capture_active <= (w_state_n == ACTIVE);
      if (!i_enable || r_state == WAIT_VS)
        r_skip_cnt <= '0;
      else if (r_state == SKIP && w_vs_rise)
        r_skip_cnt <= r_skip_cnt + 16'd1;
    end
  end

  // Byte pairing and two-stage pixel output pipeline
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase      <= 1'b0;
      r_byte0      <= '0;
      r_pix        <= '0;
      r_vld_pipe   <= '0;
      o_video_data <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_pix_fire};
      if (w_pix_fire) r_pix <= w_pix;
      if (r_vld_pipe[0]) o_video_data <= r_pix;
      if (w_byte_en && !w_phase) r_byte0 <= r_s1_data;
      if (!i_enable)
        r_phase <= 1'b0;
      else if (w_byte_en)
        r_phase <= !w_phase;
      else if (w_hr_rise || w_hr_fall)
        r_phase <= 1'b0;
    end
  end

  assign o_video_valid = r_vld_pipe[1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      o_video_width  <= '0;
      o_video_high   <= '0;
      o_odd_byte_err <= 1'b0;
    end else begin
      if (w_act && w_hr_fall && r_phase) o_odd_byte_err <= 1'b1;
      if (!i_enable || w_hr_rise)
        r_pix_cnt <= '0;
      else if (w_pix_fire && r_pix_cnt != 16'hFFFF)
        r_pix_cnt <= r_pix_cnt + 16'd1;
      if (w_line_end && r_pix_cnt != 16'd0) o_video_width <= r_pix_cnt;
      if (!i_enable) begin
        r_line_cnt <= '0;
      end else if (w_act && w_vs_rise) begin
        if (w_lines_nx != 16'd0) o_video_high <= w_lines_nx;
        r_line_cnt <= '0;
      end else begin
        r_line_cnt <= w_lines_nx;
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_pack.sv
// Randomized bench for dvp_pixel_pack: byte streams are turned into expected pixels,
// line widths and frame heights by a frame-level model and compared to the DUT.
module tb_dvp_pixel_pack;
  localparam int unsigned BO = 1;
  localparam int unsigned VP = 1;
  localparam int unsigned SK = 2;

  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, vs = 1'b0, hr = 1'b0;
  logic [7:0]  d = '0;
  logic        o_video_valid, o_video_field, o_capture_active, o_odd_byte_err;
  logic [15:0] o_video_data, o_video_width, o_video_high;

  int          errors = 0, checks = 0, field_cnt = 0;
  logic [15:0] exp_q[$], obs_q[$];
  int          frame_idx = 0, model_lines = 0, model_fields = 0;
  logic [15:0] model_width = '0, model_high = '0;
  logic        model_odd = 1'b0;

  dvp_pixel_pack #(.BYTE_ORDER(BO), .VSYNC_POL(VP), .SKIP_FRAMES(SK)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_cam_vsync(vs), .i_cam_href(hr),
    .i_cam_data(d), .o_video_valid(o_video_valid), .o_video_data(o_video_data),
    .o_video_field(o_video_field), .o_video_width(o_video_width), .o_video_high(o_video_high),
    .o_capture_active(o_capture_active), .o_odd_byte_err(o_odd_byte_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_video_valid) obs_q.push_back(o_video_data);
    if (o_video_field) field_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Frame-level model of a vsync start: previous active frame reports its line count.
  task automatic vs_rise_model();
    if (frame_idx > SK) begin
      if (model_lines != 0) model_high = 16'(model_lines);
      model_lines = 0;
    end
    frame_idx++;
    if (frame_idx > SK) model_fields++;
  endtask

  task automatic vs_pulse();
    tick(); vs = 1'b1; vs_rise_model();
    repeat (3) tick(); vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nb, input bit coincide);
    logic [7:0] b[$];
    for (int i = 0; i < nb; i++) begin tick(); hr = 1'b1; d = 8'($urandom); b.push_back(d); end
    tick(); hr = 1'b0; d = '0;
    if (coincide) vs = 1'b1;
    if (frame_idx > SK) begin
      for (int k = 0; k < nb / 2; k++)
        exp_q.push_back(BO != 0 ? {b[2*k], b[2*k+1]} : {b[2*k+1], b[2*k]});
      if (nb / 2 > 0) model_width = 16'(nb / 2);
      model_lines++;
      if (nb % 2 != 0) model_odd = 1'b1;
    end
    if (coincide) begin vs_rise_model(); repeat (3) tick(); vs = 1'b0; end
    repeat (4) tick();
  endtask

  task automatic send_frame(input int nl, input int nb);
    vs_pulse();
    for (int l = 0; l < nl; l++) send_line(nb, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #2;
    checks += 7;
    if (o_video_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", o_video_valid); end
    if (o_video_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %0h want 0", o_video_data); end
    if (o_video_field !== 1'b0) begin errors++; $display("FAIL rst_field: got %0h want 0", o_video_field); end
    if (o_video_width !== 16'h0) begin errors++; $display("FAIL rst_width: got %0h want 0", o_video_width); end
    if (o_video_high !== 16'h0) begin errors++; $display("FAIL rst_high: got %0h want 0", o_video_high); end
    if (o_capture_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %0h want 0", o_capture_active); end
    if (o_odd_byte_err !== 1'b0) begin errors++; $display("FAIL rst_odd: got %0h want 0", o_odd_byte_err); end
    #1 rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_skip_frames();
    int f0;
    en = 1'b1; repeat (4) tick();
    f0 = field_cnt;
    send_frame(4, 8); send_frame(4, 8);
    checks += 2;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL skip_no_valid: got %0d pixels want 0", obs_q.size()); end
    if (field_cnt - f0 !== 0) begin errors++; $display("FAIL skip_no_field: got %0d want 0", field_cnt - f0); end
    send_frame(4, 8); send_frame(4, 8);
    checks += 2;
    if (field_cnt - f0 !== 2) begin errors++; $display("FAIL skip_field_2: got %0d want 2", field_cnt - f0); end
    if (o_capture_active !== 1'b1) begin errors++; $display("FAIL skip_active: got %0h want 1", o_capture_active); end
    vs_pulse();
    checks += 4;
    if (field_cnt - f0 !== model_fields) begin errors++; $display("FAIL skip_field_3: got %0d want %0d", field_cnt - f0, model_fields); end
    if (o_video_width !== model_width) begin errors++; $display("FAIL skip_width: got %0d want %0d", o_video_width, model_width); end
    if (o_video_high !== model_high) begin errors++; $display("FAIL skip_high: got %0d want %0d", o_video_high, model_high); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL skip_pix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL skip_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_byte_order();
    logic [15:0] want;
    want = (BO != 0) ? 16'hABCD : 16'hCDAB;
    vs_pulse();
    tick(); hr = 1'b1; d = 8'hAB;
    tick(); d = 8'hCD;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      if (i == 1) begin #1 hr = 1'b0; d = '0; end
      @(negedge clk);
      checks++;
      if (o_video_valid !== (i == 3)) begin errors++; $display("FAIL order_valid_edge%0d: got %0h want %0h", i, o_video_valid, (i == 3)); end
      if (i == 3) begin
        checks++;
        if (o_video_data !== want) begin errors++; $display("FAIL order_data: got %h want %h", o_video_data, want); end
      end
    end
    exp_q.push_back(want);
    model_width = 16'd1; model_lines++;
    repeat (3) tick();
    checks++;
    if (o_video_width !== model_width) begin errors++; $display("FAIL order_width: got %0d want %0d", o_video_width, model_width); end
  endtask

  task automatic test_odd_line();
    vs_pulse();
    send_line(7, 1'b0);
    checks += 2;
    if (o_odd_byte_err !== 1'b1) begin errors++; $display("FAIL odd_set: got %0h want 1", o_odd_byte_err); end
    if (o_video_width !== model_width) begin errors++; $display("FAIL odd_width: got %0d want %0d", o_video_width, model_width); end
    send_frame(2, 6); send_frame(2, 6); vs_pulse();
    checks += 3;
    if (o_odd_byte_err !== model_odd) begin errors++; $display("FAIL odd_sticky: got %0h want %0h", o_odd_byte_err, model_odd); end
    if (o_video_high !== model_high) begin errors++; $display("FAIL odd_high: got %0d want %0d", o_video_high, model_high); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL odd_pix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] b[6];
    vs_pulse();
    send_line(8, 1'b0);
    for (int i = 0; i < 5; i++) begin tick(); hr = 1'b1; d = 8'($urandom); b[i] = d; end
    tick(); d = 8'($urandom); b[5] = d; en = 1'b0;
    exp_q.push_back(BO != 0 ? {b[0], b[1]} : {b[1], b[0]});
    exp_q.push_back(BO != 0 ? {b[2], b[3]} : {b[3], b[2]});
    frame_idx = 0; model_lines = 0;
    repeat (2) begin tick(); d = 8'($urandom); end
    tick(); hr = 1'b0; d = '0;
    repeat (5) tick();
    checks += 4;
    if (o_capture_active !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0h want 0", o_capture_active); end
    if (o_video_width !== model_width) begin errors++; $display("FAIL drop_width_hold: got %0d want %0d", o_video_width, model_width); end
    if (o_video_high !== model_high) begin errors++; $display("FAIL drop_high_hold: got %0d want %0d", o_video_high, model_high); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_pix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    en = 1'b1; repeat (3) tick();
    send_frame(2, 4); send_frame(2, 4);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_reskip: got %0d want %0d", obs_q.size(), exp_q.size()); end
    send_frame(2, 4); vs_pulse();
    checks += 2;
    if (o_video_high !== model_high) begin errors++; $display("FAIL drop_resume_high: got %0d want %0d", o_video_high, model_high); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL drop_resume_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_coincident();
    vs_pulse();
    send_line(4, 1'b0); send_line(4, 1'b0); send_line(6, 1'b1);
    checks += 2;
    if (o_video_high !== model_high || model_high !== 16'd3) begin errors++; $display("FAIL coinc_high: got %0d want 3", o_video_high); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL coinc_pix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL coinc_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] b[4];
    int f0, mf0;
    vs_pulse();
    for (int i = 0; i < 4; i++) begin tick(); hr = 1'b1; d = 8'($urandom); b[i] = d; end
    tick(); d = 8'($urandom);
    exp_q.push_back(BO != 0 ? {b[0], b[1]} : {b[1], b[0]});
    @(posedge clk); #3 rst_n = 1'b0; #1;
    checks += 7;
    if (o_video_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0h want 0", o_video_valid); end
    if (o_video_data !== 16'h0) begin errors++; $display("FAIL mid_rst_data: got %0h want 0", o_video_data); end
    if (o_video_field !== 1'b0) begin errors++; $display("FAIL mid_rst_field: got %0h want 0", o_video_field); end
    if (o_video_width !== 16'h0) begin errors++; $display("FAIL mid_rst_width: got %0h want 0", o_video_width); end
    if (o_video_high !== 16'h0) begin errors++; $display("FAIL mid_rst_high: got %0h want 0", o_video_high); end
    if (o_capture_active !== 1'b0) begin errors++; $display("FAIL mid_rst_active: got %0h want 0", o_capture_active); end
    if (o_odd_byte_err !== 1'b0) begin errors++; $display("FAIL mid_rst_odd: got %0h want 0", o_odd_byte_err); end
    frame_idx = 0; model_lines = 0; model_width = '0; model_high = '0; model_odd = 1'b0;
    vs = 1'b1;
    f0 = field_cnt; mf0 = model_fields;
    repeat (2) @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) begin tick(); d = 8'($urandom); end
    tick(); hr = 1'b0; d = '0;
    repeat (3) tick(); vs = 1'b0; repeat (3) tick();
    checks += 2;
    if (field_cnt - f0 !== 0) begin errors++; $display("FAIL mid_no_field: got %0d want 0", field_cnt - f0); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_no_valid: got %0d want %0d", obs_q.size(), exp_q.size()); end
    send_frame(2, 4); send_frame(2, 4); send_frame(2, 4); vs_pulse();
    checks += 4;
    if (field_cnt - f0 !== model_fields - mf0) begin errors++; $display("FAIL mid_field_count: got %0d want %0d", field_cnt - f0, model_fields - mf0); end
    if (o_video_high !== model_high) begin errors++; $display("FAIL mid_high: got %0d want %0d", o_video_high, model_high); end
    if (o_odd_byte_err !== model_odd) begin errors++; $display("FAIL mid_odd: got %0h want %0h", o_odd_byte_err, model_odd); end
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_pix_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_skip_frames();
    test_byte_order();
    test_odd_line();
    test_enable_drop();
    test_coincident();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
